// File: rtl/matrix_window_ctrl.sv
// matrix_window_ctrl: sequencer for a 3x3 window generator on a pixel stream.
// It tracks the position of each accepted pixel, drives a rotating 3-line
// buffer and flags pixels whose 3x3 neighbourhood is fully populated.
module matrix_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             frame_start,
    input  logic             wr_en,
    output logic             lb_wr_en,
    output logic [1:0]       lb_wr_sel,
    output logic [CNT_W-1:0] lb_addr,
    output logic             lb_rd_en,
    output logic             win_valid,
    output logic [CNT_W-1:0] col_cnt,
    output logic [CNT_W-1:0] row_cnt,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [1:0]       sel_q, sel_d;

    logic             lb_wr_en_q, lb_wr_en_d;
    logic [1:0]       lb_wr_sel_q, lb_wr_sel_d;
    logic [CNT_W-1:0] lb_addr_q, lb_addr_d;
    logic             lb_rd_en_q, lb_rd_en_d;
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_abort_q, frame_abort_d;
    logic             accept;

    // Next-state, position counters and registered strobes for the accepted pixel
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        sel_d         = sel_q;
        lb_wr_en_d    = 1'b0;
        lb_wr_sel_d   = lb_wr_sel_q;
        lb_addr_d     = lb_addr_q;
        lb_rd_en_d    = 1'b0;
        win_valid_d   = 1'b0;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        frame_done_d  = (state_q == DONE);
        frame_abort_d = 1'b0;
        accept        = wr_en && !frame_start && ((state_q == FILL) || (state_q == RUN));

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = FILL;
                    col_d   = '0;
                    row_d   = '0;
                    sel_d   = 2'd0;
                end
            end
            FILL, RUN: begin
                if (frame_start) begin
                    state_d       = FILL;
                    frame_abort_d = 1'b1;
                    col_d         = '0;
                    row_d         = '0;
                    sel_d         = 2'd0;
                end else if (accept) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            sel_d   = 2'd0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ONE;
                            sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                            if ((state_q == FILL) && (row_q == ONE)) begin
                                state_d = RUN;
                            end
                        end
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            DONE: begin
                state_d = frame_start ? FILL : IDLE;
                col_d   = '0;
                row_d   = '0;
                sel_d   = 2'd0;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            lb_wr_en_d  = 1'b1;
            lb_wr_sel_d = sel_q;
            lb_addr_d   = col_q;
            lb_rd_en_d  = (row_q >= ONE);
            win_valid_d = (row_q >= TWO) && (col_q >= TWO);
            col_cnt_d   = col_q;
            row_cnt_d   = row_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            sel_q         <= 2'd0;
            lb_wr_en_q    <= 1'b0;
            lb_wr_sel_q   <= 2'd0;
            lb_addr_q     <= '0;
            lb_rd_en_q    <= 1'b0;
            win_valid_q   <= 1'b0;
            col_cnt_q     <= '0;
            row_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            sel_q         <= sel_d;
            lb_wr_en_q    <= lb_wr_en_d;
            lb_wr_sel_q   <= lb_wr_sel_d;
            lb_addr_q     <= lb_addr_d;
            lb_rd_en_q    <= lb_rd_en_d;
            win_valid_q   <= win_valid_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign lb_wr_en    = lb_wr_en_q;
    assign lb_wr_sel   = lb_wr_sel_q;
    assign lb_addr     = lb_addr_q;
    assign lb_rd_en    = lb_rd_en_q;
    assign win_valid   = win_valid_q;
    assign col_cnt     = col_cnt_q;
    assign row_cnt     = row_cnt_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign busy        = (state_q == FILL) || (state_q == RUN);

endmodule
